sirene_controller: RTL and testbench

SIRENE_CONTROLLER -- requirements
Module: sirene_controller

---
 rtl/sirene_controller.sv | 129 ++++++++++++
 tb/tb_sirene_controller.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sirene_controller.sv
// Siren controller: a start button or a rising alarm edge switches the siren on.
// While it runs, a 2 Hz tick goes to the siren generator. The siren stops
// automatically after AUTO_OFF_TICKS ticks, or earlier on btn_stop. After any
// stop, a lockout period ignores every input.
module sirene_controller #(
    parameter int TICK_DIV       = 25000000,  // clock cycles per two_hz_enable pulse
    parameter int AUTO_OFF_TICKS = 120,       // ticks per activation before auto stop
    parameter int HOLDOFF_CYCLES = 50000000   // lockout cycles after any stop
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       alarm_req,
    output logic       enable_siren,
    output logic       two_hz_enable,
    output logic       active,
    output logic       holdoff,
    output logic [7:0] tick_count
);

    // Widths cover the largest legal parameter values:
    // the prescaler can reach 2^25-1 and the lockout counter can reach 2^26-2.
    localparam int PW = 25;
    localparam int HW = 26;

    localparam logic [PW-1:0] PRESCALE_LAST = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLDOFF_LAST  = HW'(HOLDOFF_CYCLES - 1);
    localparam logic [7:0]    AUTO_OFF      = 8'(AUTO_OFF_TICKS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   prescaler;
    logic [HW-1:0]   holdoff_count;
    logic            alarm_prev;
    logic            alarm_rise;

    // alarm_prev is the value of alarm_req sampled on the previous edge.
    // It resets to 1, so an alarm that is already high does not fire.
    assign alarm_rise = alarm_req & ~alarm_prev;

    // Alarm history: sampled on every edge in every state, so an alarm that
    // stays high during a lockout cannot fire again until it drops and rises.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alarm_prev <= 1'b1;
        end else begin
            alarm_prev <= alarm_req;
        end
    end

    // Main FSM. It also updates the prescaler, the lockout counter, the tick
    // counter and all outputs, and every output is registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            prescaler     <= '0;
            holdoff_count <= '0;
            tick_count    <= '0;
            enable_siren  <= 1'b0;
            two_hz_enable <= 1'b0;
            active        <= 1'b0;
            holdoff       <= 1'b0;
        end else begin
            two_hz_enable <= 1'b0;
            case (state)
                IDLE: begin
                    prescaler     <= '0;
                    holdoff_count <= '0;
                    tick_count    <= '0;
                    // A stop press held together with a start request blocks the activation.
                    if (!btn_stop && (btn_start || alarm_rise)) begin
                        state        <= ACTIVE;
                        enable_siren <= 1'b1;
                        active       <= 1'b1;
                    end
                end

                ACTIVE: begin
                    // Stop wins over a prescaler wrap on the same edge,
                    // so no tick goes out on the stopping edge.
                    if (btn_stop || (tick_count == AUTO_OFF)) begin
                        state         <= HOLDOFF;
                        enable_siren  <= 1'b0;
                        active        <= 1'b0;
                        holdoff       <= 1'b1;
                        prescaler     <= '0;
                        holdoff_count <= '0;
                    end else if (prescaler == PRESCALE_LAST) begin
                        prescaler     <= '0;
                        two_hz_enable <= 1'b1;
                        tick_count    <= tick_count + 8'd1;
                    end else begin
                        prescaler <= prescaler + PW'(1);
                    end
                end

                HOLDOFF: begin
                    // The lockout lasts HOLDOFF_CYCLES edges after the entering edge.
                    // tick_count keeps the count from the last activation.
                    if (holdoff_count == HOLDOFF_LAST) begin
                        state         <= IDLE;
                        holdoff       <= 1'b0;
                        holdoff_count <= '0;
                        tick_count    <= '0;
                    end else begin
                        holdoff_count <= holdoff_count + HW'(1);
                    end
                end

                default: begin
                    state         <= IDLE;
                    prescaler     <= '0;
                    holdoff_count <= '0;
                    tick_count    <= '0;
                    enable_siren  <= 1'b0;
                    active        <= 1'b0;
                    holdoff       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sirene_controller.sv
// Self-checking bench for sirene_controller with small parameters.
// The reference model counts edges since each state was entered and derives
// ticks from that count with plain arithmetic.
module tb_sirene_controller;

    localparam int TD = 4;   // TICK_DIV
    localparam int AO = 3;   // AUTO_OFF_TICKS
    localparam int HC = 5;   // HOLDOFF_CYCLES

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_stop = 1'b0;
    logic       alarm_req = 1'b0;
    logic       enable_siren;
    logic       two_hz_enable;
    logic       active;
    logic       holdoff;
    logic [7:0] tick_count;
    logic [11:0] observed;

    int checks = 0;
    int failures = 0;

    // Reference model state: 0 idle, 1 running, 2 lockout
    int m_state;
    int m_n;        // edges since the activation edge
    int m_h;        // edges since the lockout was entered
    int m_ticks;
    bit m_prev;
    bit m_two;

    sirene_controller #(
        .TICK_DIV(TD),
        .AUTO_OFF_TICKS(AO),
        .HOLDOFF_CYCLES(HC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .btn_start(btn_start),
        .btn_stop(btn_stop),
        .alarm_req(alarm_req),
        .enable_siren(enable_siren),
        .two_hz_enable(two_hz_enable),
        .active(active),
        .holdoff(holdoff),
        .tick_count(tick_count)
    );

    always #5 clock = ~clock;

    assign observed = {enable_siren, two_hz_enable, active, holdoff, tick_count};

    function automatic logic [11:0] expected_vec();
        logic run;
        logic lock;
        run  = (m_state == 1);
        lock = (m_state == 2);
        return {run, m_two, run, lock, 8'(m_ticks)};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_n = 0;
        m_h = 0;
        m_ticks = 0;
        m_prev = 1'b1;
        m_two = 1'b0;
    endtask

    // Drive inputs, advance one edge, update the model, then settle 1 time unit.
    task automatic step(input bit s, input bit st, input bit al);
        bit rise;
        btn_start = s;
        btn_stop = st;
        alarm_req = al;
        @(posedge clock);
        rise = al && !m_prev;
        m_prev = al;
        m_two = 1'b0;
        case (m_state)
            0: begin
                if (!st && (s || rise)) begin
                    m_state = 1;
                    m_n = 0;
                    m_ticks = 0;
                end
            end
            1: begin
                m_n++;
                if (st || m_n == AO * TD + 1) begin
                    m_state = 2;
                    m_h = 0;
                end else begin
                    m_ticks = m_n / TD;
                    m_two = (m_n % TD == 0);
                end
            end
            default: begin
                m_h++;
                if (m_h == HC) begin
                    m_state = 0;
                    m_ticks = 0;
                end
            end
        endcase
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (observed !== 12'h000) begin
            failures++;
            $display("FAIL reset_hold: got %h want %h", observed, 12'h000);
        end
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            checks++;
            if (observed !== expected_vec()) begin
                failures++;
                $display("FAIL reset_idle cyc %0d: got %h want %h", i, observed, expected_vec());
            end
        end
    endtask

    task automatic test_auto_off();
        step(1, 0, 0);
        checks++;
        if (enable_siren !== 1'b1 || active !== 1'b1) begin
            failures++;
            $display("FAIL auto_start: got en=%b act=%b want 1 1", enable_siren, active);
        end
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, 0);
            checks++;
            if (observed !== expected_vec()) begin
                failures++;
                $display("FAIL auto_off E+%0d: got %h want %h", i, observed, expected_vec());
            end
            if (i == 4 || i == 8 || i == 12) begin
                checks++;
                if (two_hz_enable !== 1'b1 || tick_count !== 8'(i / 4)) begin
                    failures++;
                    $display("FAIL auto_tick E+%0d: got two=%b cnt=%0d want 1 %0d", i, two_hz_enable, tick_count, i / 4);
                end
            end
            if (i == 13) begin
                checks++;
                if (holdoff !== 1'b1 || enable_siren !== 1'b0 || tick_count !== 8'd3) begin
                    failures++;
                    $display("FAIL auto_holdoff E+13: got hold=%b en=%b cnt=%0d want 1 0 3", holdoff, enable_siren, tick_count);
                end
            end
            if (i == 18) begin
                checks++;
                if (holdoff !== 1'b0 || active !== 1'b0) begin
                    failures++;
                    $display("FAIL auto_idle E+18: got hold=%b act=%b want 0 0", holdoff, active);
                end
            end
        end
    endtask

    task automatic test_stop_mid();
        step(1, 0, 0);
        for (int i = 1; i <= 14; i++) begin
            step(0, i == 6, 0);
            checks++;
            if (observed !== expected_vec()) begin
                failures++;
                $display("FAIL stop_mid E+%0d: got %h want %h", i, observed, expected_vec());
            end
            if (i == 6) begin
                checks++;
                if (holdoff !== 1'b1 || enable_siren !== 1'b0 || tick_count !== 8'd1) begin
                    failures++;
                    $display("FAIL stop_mid_state: got hold=%b en=%b cnt=%0d want 1 0 1", holdoff, enable_siren, tick_count);
                end
            end
        end
    endtask

    task automatic test_stop_on_wrap();
        step(1, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            step(0, i == 4, 0);
            checks++;
            if (observed !== expected_vec()) begin
                failures++;
                $display("FAIL stop_wrap E+%0d: got %h want %h", i, observed, expected_vec());
            end
            if (i == 4) begin
                checks++;
                if (two_hz_enable !== 1'b0 || tick_count !== 8'd0 || holdoff !== 1'b1) begin
                    failures++;
                    $display("FAIL stop_wrap_tick: got two=%b cnt=%0d hold=%b want 0 0 1", two_hz_enable, tick_count, holdoff);
                end
            end
        end
    endtask

    task automatic test_holdoff_ignore();
        step(1, 0, 0);
        step(0, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 0);
            checks++;
            if (observed !== expected_vec()) begin
                failures++;
                $display("FAIL holdoff_ignore H+%0d: got %h want %h", i, observed, expected_vec());
            end
        end
        checks++;
        if (holdoff !== 1'b0 || active !== 1'b0) begin
            failures++;
            $display("FAIL holdoff_exit: got hold=%b act=%b want 0 0", holdoff, active);
        end
        step(1, 0, 0);
        checks++;
        if (active !== 1'b1 || enable_siren !== 1'b1) begin
            failures++;
            $display("FAIL holdoff_restart: got act=%b en=%b want 1 1", active, enable_siren);
        end
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0);
            checks++;
            if (observed !== expected_vec()) begin
                failures++;
                $display("FAIL holdoff_rerun cyc %0d: got %h want %h", i, observed, expected_vec());
            end
        end
    endtask

    task automatic test_alarm();
        alarm_req = 1'b1;
        #2;
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        #3;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1);
            checks++;
            if (active !== 1'b0 || observed !== expected_vec()) begin
                failures++;
                $display("FAIL alarm_held cyc %0d: got %h want %h", i, observed, expected_vec());
            end
        end
        step(0, 0, 0);
        step(0, 0, 1);
        checks++;
        if (active !== 1'b1) begin
            failures++;
            $display("FAIL alarm_rise: got act=%b want 1", active);
        end
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 1);
            checks++;
            if (observed !== expected_vec()) begin
                failures++;
                $display("FAIL alarm_no_retrigger cyc %0d: got %h want %h", i, observed, expected_vec());
            end
        end
        checks++;
        if (active !== 1'b0) begin
            failures++;
            $display("FAIL alarm_final: got act=%b want 0", active);
        end
        step(0, 0, 0);
    endtask

    task automatic test_async_reset();
        step(1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (observed !== 12'h000) begin
            failures++;
            $display("FAIL async_reset: got %h want %h", observed, 12'h000);
        end
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0);
            checks++;
            if (observed !== expected_vec() || two_hz_enable !== 1'b0) begin
                failures++;
                $display("FAIL async_after cyc %0d: got %h want %h", i, observed, expected_vec());
            end
        end
    endtask

    task automatic test_random();
        bit a;
        bit s;
        bit st;
        a = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            s  = ($urandom_range(0, 7) == 0);
            st = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0) a = ~a;
            if ($urandom_range(0, 499) == 0) begin
                #2;
                reset = 1'b1;
                #1;
                checks++;
                if (observed !== 12'h000) begin
                    failures++;
                    $display("FAIL random_reset cyc %0d: got %h want %h", i, observed, 12'h000);
                end
                model_reset();
                @(posedge clock);
                #2;
                reset = 1'b0;
            end
            step(s, st, a);
            checks++;
            if (observed !== expected_vec()) begin
                failures++;
                $display("FAIL random cyc %0d: got %h want %h", i, observed, expected_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        #10;
        test_reset();
        test_auto_off();
        test_stop_mid();
        test_stop_on_wrap();
        test_holdoff_ignore();
        test_alarm();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
